disp_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the NUM_DIGITS-digit 7-segment display of the parking system.

---
 rtl/disp_pkg.sv | 28 ++
 rtl/disp_scan_ctrl_if.sv | 39 +++
 rtl/bcd_to_seg7.sv | 29 ++
 rtl/disp_scan_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_disp_scan_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display scan controller.
//
// Contents:
//   SEG_BLANK     active-low segment pattern with every segment off
//   SEG_0..SEG_9  active-low glyphs, bit0 = segment a ... bit6 = segment g
//   state_t       scan FSM state encoding (IDLE, BLANK, SHOW)
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Bus bundle between the display scan controller and its user.
//
// Signals:
//   enable      scan on (1) / display dark (0)
//   load        one-cycle strobe capturing digit_data and dp_mask
//   digit_data  packed BCD, digit i at [4i+3:4i]; codes 10..15 are blank
//   dp_mask     decimal point request per digit
//   an_n        active-low digit strobes
//   seg_n       active-low segments, bit0 = a ... bit6 = g
//   dp_n        active-low decimal point
//   dig_idx     digit currently in its slot
//   frame_done  one-cycle pulse at the end of a frame
//   upd_ack     one-cycle pulse when new digits become visible
//
// Modports: master drives the request side, slave is the controller.
interface disp_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digit_data;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [NUM_DIGITS-1:0]     an_n;
    logic [6:0]                seg_n;
    logic                      dp_n;
    logic [2:0]                dig_idx;
    logic                      frame_done;
    logic                      upd_ack;

    modport master (
        output enable, load, digit_data, dp_mask,
        input  an_n, seg_n, dp_n, dig_idx, frame_done, upd_ack
    );

    modport slave (
        input  enable, load, digit_data, dp_mask,
        output an_n, seg_n, dp_n, dig_idx, frame_done, upd_ack
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment glyph decoder.
//
// Ports:
//   code   in  4  digit code; 0..9 are glyphs, 10..15 decode to blank
//   seg_n  out 7  active-low segments, bit0 = a ... bit6 = g
module bcd_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    always_comb begin
        case (code)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
//
// Each digit owns a slot of PRESCALE cycles: the first BLANK_CYC cycles keep
// every strobe off (ghosting guard) while segments already carry the digit's
// glyph, the rest of the slot drives that digit's strobe low. Digits arrive
// through a pending buffer and only reach the active buffer at a frame
// boundary (or when scanning starts), so a frame never shows mixed values.
//
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    disp_scan_ctrl_if.slave (enable/load/digit_data/dp_mask in,
//          an_n/seg_n/dp_n/dig_idx/frame_done/upd_ack out, all registered)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, zeros above the most significant
//                          nonzero digit are shown blank (digit 0 always
//                          shown, decimal points unaffected).
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    disp_scan_ctrl_if.slave  bus
);

    localparam int                CNT_W      = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [2:0]        IDX_LAST   = 3'(NUM_DIGITS - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                      pend_flag_q, pend_flag_d;
    logic [4*NUM_DIGITS-1:0]   act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]     act_lzb_q, act_lzb_d;

    logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;
    logic [6:0]                seg_n_q, seg_n_d;
    logic                      dp_n_q, dp_n_d;
    logic [2:0]                dig_idx_q, dig_idx_d;
    logic                      frame_done_q, frame_done_d;
    logic                      upd_ack_q, upd_ack_d;

    logic                      commit;
    logic                      boundary;
    logic [NUM_DIGITS-1:0]     lzb_next;
    logic [3:0]                cur_code;
    logic                      cur_dp;
    logic                      cur_lzb;
    logic [3:0]                seg_code;
    logic [6:0]                glyph_n;

    // Blank mask for the data about to be committed: a digit is blanked while
    // it and every digit above it are zero. Digit 0 is never blanked.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic above_zero;
        lzb_next   = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            above_zero  = above_zero && (pend_data_q[4*i +: 4] == 4'd0);
            lzb_next[i] = above_zero;
        end
    end
`else
    assign lzb_next = '0;
`endif

    // Select the active digit's code, decimal point and blank flag.
    always_comb begin
        cur_code = 4'hF;
        cur_dp   = 1'b0;
        cur_lzb  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_code = act_data_q[4*i +: 4];
                cur_dp   = act_dp_q[i];
                cur_lzb  = act_lzb_q[i];
            end
        end
    end

    assign seg_code = cur_lzb ? 4'hF : cur_code;

    bcd_to_seg7 u_seg (
        .code  (seg_code),
        .seg_n (glyph_n)
    );

    // Next-state logic: FSM/slot counter, buffer handling and the pin values
    // derived from the current state (pins lag the state by one register).
    // A load coincident with a commit wins the pending flag, so that data
    // waits for the following boundary while the older pending data commits.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_flag_d = pend_flag_q;
        act_data_d  = act_data_q;
        act_dp_d    = act_dp_q;
        act_lzb_d   = act_lzb_q;
        commit      = 1'b0;
        boundary    = 1'b0;

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    commit  = pend_flag_q;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                            commit   = pend_flag_q;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        if (commit) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_lzb_d   = lzb_next;
            pend_flag_d = 1'b0;
        end

        if (bus.load) begin
            pend_data_d = bus.digit_data;
            pend_dp_d   = bus.dp_mask;
            pend_flag_d = 1'b1;
        end

        frame_done_d = boundary;
        upd_ack_d    = commit;

        // Dropping enable darkens the pins on the very next edge.
        an_n_d    = '1;
        seg_n_d   = SEG_BLANK;
        dp_n_d    = 1'b1;
        dig_idx_d = '0;
        if (bus.enable && (state_q != IDLE)) begin
            seg_n_d   = glyph_n;
            dp_n_d    = ~cur_dp;
            dig_idx_d = idx_q;
            if (state_q == SHOW) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    an_n_d[i] = (idx_q != 3'(i));
                end
            end
        end
    end

    // State, buffers and output pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_data_q  <= '1;
            pend_dp_q    <= '0;
            pend_flag_q  <= 1'b0;
            act_data_q   <= '1;
            act_dp_q     <= '0;
            act_lzb_q    <= '0;
            an_n_q       <= '1;
            seg_n_q      <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            dig_idx_q    <= '0;
            frame_done_q <= 1'b0;
            upd_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_flag_q  <= pend_flag_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_lzb_q    <= act_lzb_d;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            dig_idx_q    <= dig_idx_d;
            frame_done_q <= frame_done_d;
            upd_ack_q    <= upd_ack_d;
        end
    end

    assign bus.an_n       = an_n_q;
    assign bus.seg_n      = seg_n_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.dig_idx    = dig_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.upd_ack    = upd_ack_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (4 digits, 20-cycle slots, 4-cycle
// guard). A time-based model predicts every pin on every cycle; directed
// sequences pin start latency, frame period, commit timing, glyphs and the
// optional leading-zero blanking. Build with LEADING_ZERO_BLANK_EN defined to
// exercise the blanking variant.
module tb_disp_scan_ctrl;

    localparam int ND = 4;
    localparam int PS = 20;
    localparam int BC = 4;
    localparam int FRAME = ND * PS;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    disp_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    disp_scan_ctrl #(
        .NUM_DIGITS (ND),
        .PRESCALE   (PS),
        .BLANK_CYC  (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: buffers plus elapsed cycles into the current frame.
    logic [15:0] m_pend_data, m_act_data;
    logic [3:0]  m_pend_dp, m_act_dp, m_act_lzb;
    logic        m_pend_flag, m_running, m_valid;
    int          m_t;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd, e_ack;
    logic [2:0]  e_idx;

    // Standard active-high glyphs (gfedcba) inverted onto the active-low pins.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] hi;
        case (code)
            4'd0: hi = 7'h3F;
            4'd1: hi = 7'h06;
            4'd2: hi = 7'h5B;
            4'd3: hi = 7'h4F;
            4'd4: hi = 7'h66;
            4'd5: hi = 7'h6D;
            4'd6: hi = 7'h7D;
            4'd7: hi = 7'h07;
            4'd8: hi = 7'h7F;
            4'd9: hi = 7'h6F;
            default: hi = 7'h00;
        endcase
        return ~hi;
    endfunction

    function automatic logic [3:0] lzbOf(input logic [15:0] data);
        logic [3:0] m;
        m = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = ND - 1; i >= 1; i--) begin
            if (data[4*i +: 4] != 4'd0) break;
            m[i] = 1'b1;
        end
`else
        if (data == 16'hFFFF) m = 4'b0000;
`endif
        return m;
    endfunction

    // One clock of the model: predicts the pins that appear after this edge.
    task automatic modelStep();
        logic [15:0] pd_old;
        logic [3:0]  pdp_old;
        logic        pf_old, commit;
        logic [3:0]  one, code;
        int          d, ph;
        one = 4'b0001;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 3'd0;
        e_fd = 1'b0; e_ack = 1'b0;
        if (!rst_n) begin
            m_pend_data = 16'hFFFF; m_act_data = 16'hFFFF;
            m_pend_dp = 4'h0; m_act_dp = 4'h0; m_act_lzb = 4'h0;
            m_pend_flag = 1'b0; m_running = 1'b0; m_t = 0;
            m_valid = 1'b1;
            return;
        end
        pd_old = m_pend_data; pdp_old = m_pend_dp; pf_old = m_pend_flag;
        commit = 1'b0;
        if (!bus.enable) begin
            m_running = 1'b0;
            m_t = 0;
        end else if (!m_running) begin
            commit = pf_old;
            m_running = 1'b1;
            m_t = 0;
        end else begin
            d  = m_t / PS;
            ph = m_t % PS;
            e_idx = 3'(d);
            if (ph >= BC) e_an = ~(one << d);
            code = m_act_lzb[d] ? 4'hF : m_act_data[4*d +: 4];
            e_seg = glyph(code);
            e_dp = ~m_act_dp[d];
            if (m_t == FRAME - 1) begin
                e_fd = 1'b1;
                commit = pf_old;
            end
            m_t = (m_t + 1) % FRAME;
        end
        e_ack = commit;
        if (commit) begin
            m_act_data = pd_old; m_act_dp = pdp_old;
            m_act_lzb = lzbOf(pd_old);
            m_pend_flag = 1'b0;
        end
        if (bus.load) begin
            m_pend_data = bus.digit_data;
            m_pend_dp = bus.dp_mask;
            m_pend_flag = 1'b1;
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("cyc_an_n", 32'(bus.an_n), 32'(e_an));
        checkVal("cyc_seg_n", 32'(bus.seg_n), 32'(e_seg));
        checkVal("cyc_dp_n", 32'(bus.dp_n), 32'(e_dp));
        checkVal("cyc_dig_idx", 32'(bus.dig_idx), 32'(e_idx));
        checkVal("cyc_frame_done", 32'(bus.frame_done), 32'(e_fd));
        checkVal("cyc_upd_ack", 32'(bus.upd_ack), 32'(e_ack));
    endtask

    // Compare process: model advances on each edge, pins sampled 1 time unit later.
    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            if (m_valid) checkOutput();
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                                 input logic [15:0] data, input logic [3:0] dp);
        rst_n = rst;
        bus.enable = en;
        bus.load = ld;
        bus.digit_data = data;
        bus.dp_mask = dp;
        tick();
    endtask

    function automatic logic [7:0] sigVal(input int sel);
        case (sel)
            0: return {4'h0, bus.an_n};
            1: return {7'h0, bus.frame_done};
            default: return {7'h0, bus.upd_ack};
        endcase
    endfunction

    // Waits (bounded) until the selected signal equals val; n = cycles waited.
    task automatic waitFor(input string name, input int sel, input logic [7:0] val,
                           input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (sigVal(sel) == val) begin
                n = k;
                break;
            end
        end
        checkVal(name, 32'(n > 0), 32'd1);
    endtask

    // Edges from the first enabled, out-of-reset edge until digit 0 strobes.
    task automatic measureStart(output int lat);
        lat = -1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (bus.an_n == 4'hE) begin
                lat = e;
                break;
            end
        end
    endtask

    initial begin
        int n, lat;
        logic [15:0] rd;
        logic        en;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.load = 1'b0;
        bus.digit_data = 16'h0;
        bus.dp_mask = 4'h0;

        // Reset held with enable high: everything dark.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        checkVal("rst_an_n", 32'(bus.an_n), 32'hF);
        checkVal("rst_seg_n", 32'(bus.seg_n), 32'h7F);
        checkVal("rst_dp_n", 32'(bus.dp_n), 32'h1);
        checkVal("rst_dig_idx", 32'(bus.dig_idx), 32'h0);
        rst_n = 1'b1;
        measureStart(lat);
        checkVal("start_latency", 32'(lat), 32'd5);

        // Load 1234 with dp on digit 2, commit at the first boundary.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 4'b0100);
        bus.load = 1'b0;
        waitFor("ack_seen", 2, 8'h1, 200, n);
        checkVal("ack_with_frame_done", 32'(bus.frame_done), 32'h1);
        waitFor("fd_seen", 1, 8'h1, 200, n);
        checkVal("frame_period", 32'(n), 32'(FRAME));
        waitFor("dig0_seen", 0, 8'hE, 200, n);
        checkVal("dig0_seg_4", 32'(bus.seg_n), 32'h19);
        checkVal("dig0_dp_off", 32'(bus.dp_n), 32'h1);
        waitFor("dig2_seen", 0, 8'hB, 200, n);
        checkVal("dig2_seg_2", 32'(bus.seg_n), 32'h24);
        checkVal("dig2_dp_on", 32'(bus.dp_n), 32'h0);

        // Load landing exactly in the boundary cycle waits one more frame.
        waitFor("fd_sync", 1, 8'h1, 200, n);
        repeat (FRAME - 1) tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555, 4'h0);
        bus.load = 1'b0;
        checkVal("bnd_load_fd", 32'(bus.frame_done), 32'h1);
        checkVal("bnd_load_no_ack", 32'(bus.upd_ack), 32'h0);
        repeat (FRAME) tick();
        checkVal("bnd_load_next_fd", 32'(bus.frame_done), 32'h1);
        checkVal("bnd_load_next_ack", 32'(bus.upd_ack), 32'h1);

        // Drop enable while digit 2 is strobed, then restart.
        waitFor("dig2_show", 0, 8'hB, 200, n);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        checkVal("dis_an_n", 32'(bus.an_n), 32'hF);
        checkVal("dis_dig_idx", 32'(bus.dig_idx), 32'h0);
        checkVal("dis_seg_n", 32'(bus.seg_n), 32'h7F);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        bus.enable = 1'b1;
        measureStart(lat);
        checkVal("restart_latency", 32'(lat), 32'd5);

        // Code A on digit 1 is blank.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h30A5, 4'h0);
        bus.load = 1'b0;
        waitFor("codeA_ack", 2, 8'h1, 200, n);
        waitFor("codeA_dig1", 0, 8'hD, 200, n);
        checkVal("codeA_blank", 32'(bus.seg_n), 32'h7F);

        // Leading zeros.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0070, 4'h0);
        bus.load = 1'b0;
        waitFor("lz_ack", 2, 8'h1, 200, n);
        waitFor("lz_dig1", 0, 8'hD, 200, n);
        checkVal("lz_dig1_7", 32'(bus.seg_n), 32'h78);
        waitFor("lz_dig2", 0, 8'hB, 200, n);
`ifdef LEADING_ZERO_BLANK_EN
        checkVal("lz_dig2", 32'(bus.seg_n), 32'h7F);
`else
        checkVal("lz_dig2", 32'(bus.seg_n), 32'h40);
`endif
        waitFor("lz_dig3", 0, 8'h7, 200, n);
`ifdef LEADING_ZERO_BLANK_EN
        checkVal("lz_dig3", 32'(bus.seg_n), 32'h7F);
`else
        checkVal("lz_dig3", 32'(bus.seg_n), 32'h40);
`endif
        waitFor("lz_dig0", 0, 8'hE, 200, n);
        checkVal("lz_dig0_0", 32'(bus.seg_n), 32'h40);

        // Randomized traffic checked by the model alone.
        en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (!en) begin
                if ($urandom_range(0, 4) == 0) en = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                en = 1'b0;
            end
            for (int i = 0; i < ND; i++) begin
                rd[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            applyStimulus(($urandom_range(0, 799) != 0), en,
                          ($urandom_range(0, 29) == 0), rd, 4'($urandom));
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stalled bench.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
